// File: rtl/scatter_xbar_if.sv
// Handshake bundle for scatter_xbar: producer-side element/dest/valid/ready and
// consumer-side registered element/src/valid/ready.
interface scatter_xbar_if #(
    parameter int unsigned ElemWidth = 8,
    parameter int unsigned NumElem   = 4
);
    localparam int unsigned IdxW = $clog2(NumElem);

    logic [NumElem-1:0][ElemWidth-1:0] in_data_i;
    logic [NumElem-1:0][IdxW-1:0]      in_dest_i;
    logic [NumElem-1:0]                in_valid_i;
    logic [NumElem-1:0]                in_ready_o;
    logic [NumElem-1:0][ElemWidth-1:0] out_data_o;
    logic [NumElem-1:0][IdxW-1:0]      out_src_o;
    logic [NumElem-1:0]                out_valid_o;
    logic [NumElem-1:0]                out_ready_i;

    // Crossbar side.
    modport slave (
        input  in_data_i, in_dest_i, in_valid_i, out_ready_i,
        output in_ready_o, out_data_o, out_src_o, out_valid_o
    );

    // Producer/consumer side.
    modport master (
        output in_data_i, in_dest_i, in_valid_i, out_ready_i,
        input  in_ready_o, out_data_o, out_src_o, out_valid_o
    );
endinterface

// File: rtl/scatter_xbar.sv
// Destination-routed crossbar with per-output round-robin arbitration and a one-entry
// output register. Define SCATTER_XBAR_FIXED_PRIO_EN for fixed lowest-index priority.
module scatter_xbar #(
    parameter int unsigned ElemWidth = 8,
    parameter int unsigned NumElem   = 4
) (
    input logic           clk_i,
    input logic           arst_ni,
    scatter_xbar_if.slave bus
);
    localparam int unsigned IdxW = $clog2(NumElem);
    typedef logic [IdxW-1:0] idx_t;

    logic [NumElem-1:0][NumElem-1:0]   req;  // req[j][i]: input i targets output j
    logic [NumElem-1:0]                slot_free;
    logic [NumElem-1:0]                load;
    idx_t [NumElem-1:0]                win;
    logic [NumElem-1:0]                in_ready;

    logic [NumElem-1:0][ElemWidth-1:0] data_q, data_d;
    idx_t [NumElem-1:0]                src_q, src_d;
    logic [NumElem-1:0]                valid_q, valid_d;
`ifndef SCATTER_XBAR_FIXED_PRIO_EN
    localparam idx_t PtrRst = idx_t'(NumElem - 1);
    idx_t [NumElem-1:0]                ptr_q, ptr_d;
`endif

    // Out-of-range destinations fold back by NumElem (only reachable for non-power-of-2).
    always_comb begin
        int unsigned eff;
        req = '0;
        eff = 0;
        for (int unsigned i = 0; i < NumElem; i++) begin
            eff = 32'(bus.in_dest_i[i]);
            if (eff >= NumElem) eff = eff - NumElem;
            for (int unsigned j = 0; j < NumElem; j++) begin
                req[j][i] = bus.in_valid_i[i] && (eff == j);
            end
        end
    end

    always_comb begin
        logic        found;
        int unsigned cand;
        load      = '0;
        win       = '0;
        slot_free = '0;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned j = 0; j < NumElem; j++) begin
            found = 1'b0;
`ifdef SCATTER_XBAR_FIXED_PRIO_EN
            for (int unsigned k = 0; k < NumElem; k++) begin
                if (!found && req[j][k]) begin
                    found  = 1'b1;
                    win[j] = idx_t'(k);
                end
            end
`else
            // Search starts just after the last granted input and wraps.
            for (int unsigned k = 1; k <= NumElem; k++) begin
                cand = 32'(ptr_q[j]) + k;
                if (cand >= NumElem) cand = cand - NumElem;
                if (!found && req[j][idx_t'(cand)]) begin
                    found  = 1'b1;
                    win[j] = idx_t'(cand);
                end
            end
`endif
            slot_free[j] = !valid_q[j] || bus.out_ready_i[j];
            load[j]      = found && slot_free[j];
        end
    end

    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < NumElem; i++) begin
            for (int unsigned j = 0; j < NumElem; j++) begin
                if (load[j] && (win[j] == idx_t'(i))) in_ready[i] = 1'b1;
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        src_d   = src_q;
        valid_d = valid_q;
`ifndef SCATTER_XBAR_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        for (int unsigned j = 0; j < NumElem; j++) begin
            if (load[j]) begin
                data_d[j]  = bus.in_data_i[win[j]];
                src_d[j]   = win[j];
                valid_d[j] = 1'b1;
`ifndef SCATTER_XBAR_FIXED_PRIO_EN
                ptr_d[j]   = win[j];
`endif
            end else if (bus.out_ready_i[j]) begin
                valid_d[j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            data_q  <= '0;
            src_q   <= '0;
            valid_q <= '0;
`ifndef SCATTER_XBAR_FIXED_PRIO_EN
            ptr_q   <= {NumElem{PtrRst}};
`endif
        end else begin
            data_q  <= data_d;
            src_q   <= src_d;
            valid_q <= valid_d;
`ifndef SCATTER_XBAR_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_data_o  = data_q;
    assign bus.out_src_o   = src_q;
    assign bus.out_valid_o = valid_q;
endmodule

// File: tb/tb_scatter_xbar.sv
// Bench for scatter_xbar: directed scenarios plus random traffic against an
// arbitration-by-distance reference model (NumElem=4), and a fold check at NumElem=6.
module tb_scatter_xbar;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    scatter_xbar_if #(.ElemWidth(8), .NumElem(4)) bus4 ();
    scatter_xbar_if #(.ElemWidth(8), .NumElem(6)) bus6 ();

    scatter_xbar #(.ElemWidth(8), .NumElem(4)) dut4 (.clk_i(clk), .arst_ni(arst_n), .bus(bus4));
    scatter_xbar #(.ElemWidth(8), .NumElem(6)) dut6 (.clk_i(clk), .arst_ni(arst_n), .bus(bus6));

    // Reference state for the 4-wide instance.
    logic [7:0] m_data[4];
    int         m_src[4];
    logic       m_valid[4];
    int         m_ptr[4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 4; j++) begin
            m_data[j] = '0; m_src[j] = 0; m_valid[j] = 1'b0; m_ptr[j] = 3;
        end
    endtask

    // Winner per output = requester nearest after the last grant (or lowest index).
    task automatic model_step(output logic [3:0] rdy);
        int best[4];
        int bestd[4];
        int j, d;
        for (int k = 0; k < 4; k++) begin best[k] = -1; bestd[k] = 99; end
        for (int i = 0; i < 4; i++) begin
            if (bus4.in_valid_i[i]) begin
                j = int'(bus4.in_dest_i[i]);
`ifdef SCATTER_XBAR_FIXED_PRIO_EN
                d = i;
`else
                d = (i - m_ptr[j] - 1 + 8) % 4;
`endif
                if (d < bestd[j]) begin bestd[j] = d; best[j] = i; end
            end
        end
        rdy = '0;
        for (int k = 0; k < 4; k++) begin
            if (best[k] >= 0 && (!m_valid[k] || bus4.out_ready_i[k])) begin
                rdy[best[k]] = 1'b1;
                m_data[k]    = bus4.in_data_i[best[k]];
                m_src[k]     = best[k];
                m_valid[k]   = 1'b1;
                m_ptr[k]     = best[k];
            end else if (bus4.out_ready_i[k]) begin
                m_valid[k] = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] exp_data();
        logic [31:0] v;
        for (int j = 0; j < 4; j++) v[j*8 +: 8] = m_data[j];
        return v;
    endfunction

    function automatic logic [7:0] exp_src();
        logic [7:0] v;
        for (int j = 0; j < 4; j++) v[j*2 +: 2] = 2'(m_src[j]);
        return v;
    endfunction

    function automatic logic [3:0] exp_valid();
        logic [3:0] v;
        for (int j = 0; j < 4; j++) v[j] = m_valid[j];
        return v;
    endfunction

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle4(output logic [3:0] rdy_seen);
        logic [3:0] exp_rdy;
        #1;
        model_step(exp_rdy);
        rdy_seen = bus4.in_ready_o;
        check("in_ready", 64'(rdy_seen), 64'(exp_rdy));
        @(posedge clk);
        #1;
        check("out_valid", 64'(bus4.out_valid_o), 64'(exp_valid()));
        check("out_data", 64'(bus4.out_data_o), 64'(exp_data()));
        check("out_src", 64'(bus4.out_src_o), 64'(exp_src()));
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus4.in_valid_i = '0; bus4.in_data_i = '0; bus4.in_dest_i = '0; bus4.out_ready_i = '0;
        bus6.in_valid_i = '0; bus6.in_data_i = '0; bus6.in_dest_i = '0; bus6.out_ready_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        arst_n = 1'b0;
        model_reset();
        #2;
        arst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] last_rdy;
        int         exp_rr;

        // Reset with random inputs applied.
        idle_inputs();
        model_reset();
        bus4.in_valid_i  = 4'($urandom);
        bus4.in_data_i   = $urandom;
        bus4.in_dest_i   = 8'($urandom);
        bus4.out_ready_i = 4'($urandom);
        @(posedge clk);
        #1;
        check("rst_valid", 64'(bus4.out_valid_o), 64'(0));
        check("rst_data", 64'(bus4.out_data_o), 64'(0));
        check("rst_src", 64'(bus4.out_src_o), 64'(0));
        check("rst_valid6", 64'(bus6.out_valid_o), 64'(0));
        @(negedge clk);
        idle_inputs();
        arst_n = 1'b1;
        #1;
        check("rst_ready_idle", 64'(bus4.in_ready_o), 64'(0));
        @(negedge clk);

        // Permutation.
        do_reset();
        bus4.out_ready_i = 4'hF;
        bus4.in_valid_i  = 4'hF;
        bus4.in_data_i   = 32'hA3A2A1A0;
        bus4.in_dest_i   = 8'b00_01_10_11;
        cycle4(r);
        check("perm_ready", 64'(r), 64'(4'hF));
        check("perm_data", 64'(bus4.out_data_o), 64'(32'hA0A1A2A3));
        check("perm_src", 64'(bus4.out_src_o), 64'(8'h1B));

        // Round-robin contention on output 1.
        do_reset();
        bus4.out_ready_i = 4'hF;
        bus4.in_valid_i  = 4'b0111;
        bus4.in_data_i   = 32'h00121110;
        bus4.in_dest_i   = 8'b00_01_01_01;
        for (int c = 0; c < 6; c++) begin
            cycle4(r);
`ifdef SCATTER_XBAR_FIXED_PRIO_EN
            exp_rr = 0;
`else
            exp_rr = c % 3;
`endif
            check("rr_onehot", 64'($countones(r)), 64'(1));
            check("rr_src", 64'(bus4.out_src_o[1]), 64'(exp_rr));
        end

        // Back-pressure on output 2.
        do_reset();
        bus4.out_ready_i = 4'b1011;
        bus4.in_valid_i  = 4'b0001;
        bus4.in_data_i   = 32'h00000055;
        bus4.in_dest_i   = 8'b00_00_00_10;
        cycle4(r);
        check("bp_accept0", 64'(r), 64'(4'b0001));
        bus4.in_valid_i = 4'b0010;
        bus4.in_data_i  = 32'h00006600;
        bus4.in_dest_i  = 8'b00_00_10_00;
        cycle4(r);
        check("bp_block1", 64'(r[1]), 64'(0));
        check("bp_hold55", 64'(bus4.out_data_o[2]), 64'(8'h55));
        bus4.out_ready_i = 4'hF;
        cycle4(r);
        check("bp_release1", 64'(r[1]), 64'(1));
        check("bp_data66", 64'(bus4.out_data_o[2]), 64'(8'h66));
        check("bp_nobubble", 64'(bus4.out_valid_o[2]), 64'(1));

        // Destination fold at NumElem=6.
        do_reset();
        bus6.out_ready_i = 6'h3F;
        bus6.in_valid_i  = 6'b110000;
        bus6.in_data_i[4] = 8'hC4;
        bus6.in_data_i[5] = 8'hC5;
        bus6.in_dest_i[4] = 3'd7;
        bus6.in_dest_i[5] = 3'd6;
        #1;
        check("fold_ready", 64'(bus6.in_ready_o), 64'(6'b110000));
        @(posedge clk);
        #1;
        check("fold_data1", 64'(bus6.out_data_o[1]), 64'(8'hC4));
        check("fold_data0", 64'(bus6.out_data_o[0]), 64'(8'hC5));
        check("fold_src1", 64'(bus6.out_src_o[1]), 64'(4));
        check("fold_src0", 64'(bus6.out_src_o[0]), 64'(5));
        check("fold_valid", 64'(bus6.out_valid_o), 64'(6'b000011));
        @(negedge clk);

        // Reset in the middle of a held element.
        do_reset();
        bus4.out_ready_i = 4'b0111;
        bus4.in_valid_i  = 4'b0001;
        bus4.in_data_i   = 32'h0000005A;
        bus4.in_dest_i   = 8'b00_00_00_11;
        cycle4(r);
        check("mid_loaded", 64'(bus4.out_data_o[3]), 64'(8'h5A));
        bus4.in_valid_i = '0;
        arst_n = 1'b0;
        #1;
        check("mid_async_valid", 64'(bus4.out_valid_o[3]), 64'(0));
        check("mid_async_data", 64'(bus4.out_data_o[3]), 64'(0));
        #1;
        arst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            bus4.out_ready_i = 4'($urandom);
            cycle4(r);
            check("mid_gone", 64'(bus4.out_data_o[3]), 64'(0));
        end

        // Random traffic; stalled producers keep data/dest stable.
        do_reset();
        last_rdy = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!(bus4.in_valid_i[i] && !last_rdy[i])) begin
                    bus4.in_valid_i[i] = ($urandom_range(0, 99) < 60);
                    bus4.in_data_i[i]  = 8'($urandom);
                    bus4.in_dest_i[i]  = 2'($urandom_range(0, 3));
                end
                bus4.out_ready_i[i] = ($urandom_range(0, 99) < 70);
            end
            cycle4(last_rdy);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
